// File: rtl/hb_decim2.sv
// Half-band decimate-by-2 FIR (taps -1,0,9,16,9,0,-1 / 32) with a sequential 3-step MAC.
// Define HB_SAT_EN to saturate the output to 16 bits; otherwise the result wraps.
module hb_decim2 #(
  parameter int unsigned OUT_SHIFT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overrun,
  output logic        out_drop
);

  localparam int unsigned DW       = 16;
  localparam int unsigned SW       = DW + 1;
  localparam int unsigned AW       = 22;
  localparam int unsigned TAPS     = 7;
  localparam int unsigned RND_BIAS = 1 << (OUT_SHIFT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC1,
    S_MAC2,
    S_MAC3,
    S_RND
  } state_e;

  state_e                   state_q, state_d;
  logic [TAPS-1:0][DW-1:0]  x_q, x_d;
  logic                     phase_q, phase_d;
  logic signed [AW-1:0]     acc_q, acc_d;
  logic [DW-1:0]            out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     overrun_q, overrun_d;
  logic                     out_drop_q, out_drop_d;

  logic signed [SW-1:0]     pair_sum;
  logic signed [AW-1:0]     rnd_sum;
  logic signed [AW-1:0]     shifted;
  logic [DW-1:0]            rnd_res;

  // Round half-up, scale back, then saturate or wrap to 16 bits
  always_comb begin
    rnd_sum = acc_q + $signed(AW'(RND_BIAS));
    shifted = rnd_sum >>> OUT_SHIFT;
`ifdef HB_SAT_EN
    if (shifted > AW'(32'sd32767)) begin
      rnd_res = 16'h7fff;
    end else if (shifted < AW'(-32'sd32768)) begin
      rnd_res = 16'h8000;
    end else begin
      rnd_res = DW'(shifted);
    end
`else
    rnd_res = DW'(shifted);
`endif
  end

  // Next-state: sample intake, MAC sequencing and output handshake
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    phase_d     = phase_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !out_ready;
    overrun_d   = overrun_q;
    out_drop_d  = out_drop_q;
    pair_sum    = '0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d     = {x_q[TAPS-2:0], in_data};
          phase_d = !phase_q;
          if (phase_q) begin
            state_d = S_MAC1;
          end
        end
      end
      S_MAC1: begin
        acc_d   = AW'($signed(x_q[3])) <<< 4;
        state_d = S_MAC2;
      end
      S_MAC2: begin
        pair_sum = SW'($signed(x_q[2])) + SW'($signed(x_q[4]));
        acc_d    = acc_q + (AW'(pair_sum) <<< 3) + AW'(pair_sum);
        state_d  = S_MAC3;
      end
      S_MAC3: begin
        pair_sum = SW'($signed(x_q[0])) + SW'($signed(x_q[6]));
        acc_d    = acc_q - AW'(pair_sum);
        state_d  = S_RND;
      end
      S_RND: begin
        out_data_d  = rnd_res;
        out_valid_d = 1'b1;
        if (out_valid_q && !out_ready) begin
          out_drop_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Samples arriving mid-computation are lost; flag it
    if (in_valid && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      phase_q     <= 1'b0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      out_drop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      phase_q     <= phase_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      out_drop_q  <= out_drop_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign out_drop  = out_drop_q;

endmodule

// File: tb/tb_hb_decim2.sv
// Directed bench for hb_decim2: impulse, DC, saturation, backpressure, overrun and reset cases.
module tb_hb_decim2;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic [15:0] in_data   = '0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_valid;
  logic        overrun;
  logic        out_drop;

  int n_checks = 0;
  int n_pass   = 0;

  int imp_exp [5] = '{-32, 288, 288, -32, 0};
  int sat_in  [8] = '{0, -32768, 0, 32767, 32767, 32767, 0, -32768};
`ifdef HB_SAT_EN
  int sat_exp [4] = '{1024, -10240, -1024, 32767};
`else
  int sat_exp [4] = '{1024, -10240, -1024, -28673};
`endif

  hb_decim2 #(.OUT_SHIFT(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overrun  (overrun),
    .out_drop (out_drop)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One-cycle input strobe; returns at the negedge of the cycle after sampling
  task automatic push(input int v);
    @(negedge clk);
    in_data  = 16'(v);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, output int r, output int lat);
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_valid"}, int'(out_valid), 1);
    r = int'($signed(out_data));
  endtask

  task automatic pair(input string tag, input int a, input int b, output int r, output int lat);
    push(a);
    push(b);
    wait_out(tag, r, lat);
  endtask

  initial begin
    int r;
    int lat;
    int seen;

    repeat (3) @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_out_drop", int'(out_drop), 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      pair($sformatf("imp%0d", i), 0, (i == 0) ? 1024 : 0, r, lat);
      check($sformatf("imp%0d_data", i), r, imp_exp[i]);
      if (i == 0) check("imp_latency", lat, 5);
    end

    do_reset();
    for (int i = 0; i < 5; i++) begin
      pair($sformatf("dc%0d", i), 1000, 1000, r, lat);
      if (i >= 3) check($sformatf("dc%0d_data", i), r, 1000);
    end
    check("dc_overrun", int'(overrun), 0);
    check("dc_out_drop", int'(out_drop), 0);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      pair($sformatf("sat%0d", i), sat_in[2*i], sat_in[2*i+1], r, lat);
      check($sformatf("sat%0d_data", i), r, sat_exp[i]);
    end

    do_reset();
    out_ready = 1'b0;
    pair("bp1", 0, 1024, r, lat);
    check("bp1_data", r, -32);
    check("bp1_drop", int'(out_drop), 0);
    push(0);
    check("bp_hold_data", int'($signed(out_data)), -32);
    push(0);
    repeat (4) @(negedge clk);
    check("bp2_valid", int'(out_valid), 1);
    check("bp2_data", int'($signed(out_data)), 288);
    check("bp2_drop", int'(out_drop), 1);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", int'(out_valid), 0);

    do_reset();
    push(0);
    push(1024);
    @(negedge clk);
    in_data  = 16'd5000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out("ovr1", r, lat);
    check("ovr1_data", r, -32);
    check("ovr_flag", int'(overrun), 1);
    pair("ovr2", 0, 0, r, lat);
    check("ovr2_data", r, 288);

    do_reset();
    push(0);
    push(1024);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'd7777;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("rstmac_no_valid", seen, 0);
    check("rstmac_data", int'(out_data), 0);
    check("rstmac_overrun", int'(overrun), 0);
    check("rstmac_drop", int'(out_drop), 0);
    push(1024);
    repeat (6) @(negedge clk);
    check("rstmac_first_no_trig", int'(out_valid), 0);
    push(2048);
    wait_out("rstmac_trig", r, lat);
    check("rstmac_trig_data", r, -64);
    check("rstmac_trig_latency", lat, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
